axi4_rd_dma: RTL

AXI4_RD_DMA -- requirements
Module: axi4_rd_dma

---
 rtl/axi4_rd_pkg.sv | 26 ++
 rtl/axi4_rd_len_calc.sv | 33 +++
 rtl/axi4_rd_dma.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_rd_pkg.sv
// axi4_rd_pkg: shared AXI4 read-DMA constants, FSM state type and clogb2 helper.
// Contents: BURST_INCR, RESP_SLVERR, RESP_DECERR, ARCACHE_VAL, state_t, clogb2().
package axi4_rd_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [3:0] ARCACHE_VAL = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Ceiling log2; exact log2 for powers of two.
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/axi4_rd_len_calc.sv
// axi4_rd_len_calc: burst length = min(beats remaining, MAX_BURST_LEN, beats to next 4 KB page).
// Ports: page_off (low 12 address bits, beat aligned), beats_left (beats still to request),
//        len (resulting burst length in beats, 1..256).
module axi4_rd_len_calc #(
    parameter int BEATS_W       = 17,
    parameter int OFF_W         = 2,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]        page_off,
    input  logic [BEATS_W-1:0] beats_left,
    output logic [8:0]         len
);

    localparam int W = (BEATS_W > 13) ? BEATS_W : 13;

    logic [12:0]  to_page;
    logic [W-1:0] page_beats;
    logic [W-1:0] left_ext;
    logic [W-1:0] cap;
    logic [W-1:0] min_a;
    logic [W-1:0] min_b;

    always_comb begin
        to_page    = 13'h1000 - {1'b0, page_off};
        page_beats = W'(to_page >> OFF_W);
        left_ext   = W'(beats_left);
        cap        = W'(MAX_BURST_LEN);
        min_a      = (left_ext < cap) ? left_ext : cap;
        min_b      = (page_beats < min_a) ? page_beats : min_a;
        len        = 9'(min_b);
    end

endmodule

// File: rtl/axi4_rd_dma.sv
// axi4_rd_dma: AXI4 read-burst DMA copying byte_num_i bytes from base_addr_i into a word SRAM.
// Ports: clk, rst_n (async, active low); start_i/base_addr_i/byte_num_i command;
//        busy_o, done_o (1-cycle pulse), error_o (sticky RRESP error);
//        sram_we_o/sram_be_o/sram_addr_o/sram_data_o SRAM write port;
//        M_AXI_AR* / M_AXI_R* AXI4 read address and read data channels.
// Option: define AXI4_RD_ERR_ABORT_EN to stop issuing ARs after the first error and
//         drain in-flight bursts without writing them.
module axi4_rd_dma
    import axi4_rd_pkg::*;
#(
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int BYTE_NUM_WIDTH  = 16,
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [BYTE_NUM_WIDTH-1:0]   byte_num_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        sram_we_o,
    output logic [AXI_DATA_WIDTH/8-1:0] sram_be_o,
    output logic [SRAM_ADDR_WIDTH-1:0]  sram_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]   sram_data_o,
    output logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARLOCK,
    output logic [3:0]                  M_AXI_ARCACHE,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic [3:0]                  M_AXI_ARQOS,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int STRB  = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = clogb2(STRB);
    localparam int BW    = BYTE_NUM_WIDTH + 1;
    localparam int OW    = clogb2(MAX_OUTSTANDING + 1);
    localparam logic [STRB-1:0] ONES = '1;

    state_t                    state;
    state_t                    state_nx;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic                      ar_valid;
    logic [BW-1:0]             ar_left;
    logic [BW-1:0]             total;
    logic [BW-1:0]             r_cnt;
    logic [OW-1:0]             outstanding;
    logic [OFF_W-1:0]          off;
    logic [OFF_W-1:0]          end_off;
    logic [8:0]                calc_len;
    logic [8:0]                cur_len;
    logic [BW-1:0]             start_sum;
    logic [BW-1:0]             start_beats;
    logic [STRB-1:0]           first_m;
    logic [STRB-1:0]           last_m;
    logic                      start_ok;
    logic                      ar_hs;
    logic                      ar_issue;
    logic                      r_hs;
    logic                      r_end;
    logic                      r_err;
    logic                      halt;
    logic                      unused;

    assign start_ok    = (state == ST_IDLE) && start_i;
    assign ar_hs       = ar_valid && M_AXI_ARREADY;
    assign r_hs        = M_AXI_RVALID && M_AXI_RREADY;
    assign r_end       = r_hs && M_AXI_RLAST;
    assign r_err       = r_hs && M_AXI_RRESP[1];
    assign cur_len     = {1'b0, ar_len} + 9'd1;
    // Beat count covers the partial leading word as well as the trailing one.
    assign start_sum   = BW'(base_addr_i[OFF_W-1:0]) + BW'(byte_num_i);
    assign start_beats = (start_sum + BW'(STRB - 1)) >> OFF_W;
    assign first_m     = (r_cnt == '0) ? (ONES << off) : ONES;
    assign last_m      = ((r_cnt == total - BW'(1)) && (end_off != '0)) ? ~(ONES << end_off) : ONES;

`ifdef AXI4_RD_ERR_ABORT_EN
    // Once an error is seen the remaining data is worthless: stop requesting and discard.
    assign halt = error_o || r_err;
`else
    assign halt = 1'b0;
`endif

    // A new AR is raised only after the previous one handshakes, so at most one is pending.
    assign ar_issue = (state == ST_RUN) && !ar_valid && (ar_left != '0) &&
                      (outstanding < OW'(MAX_OUTSTANDING)) && !halt;

    assign busy_o        = (state != ST_IDLE);
    assign done_o        = (state == ST_DONE);
    assign M_AXI_RREADY  = (state == ST_RUN) || (state == ST_DRAIN);
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_ARLEN   = ar_len;
    assign M_AXI_ARSIZE  = 3'(OFF_W);
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = ARCACHE_VAL;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = ar_valid;
    assign unused        = ^{M_AXI_RID, M_AXI_RRESP[0]};

    axi4_rd_len_calc #(
        .BEATS_W       (BW),
        .OFF_W         (OFF_W),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .page_off   (ar_addr[11:0]),
        .beats_left (ar_left),
        .len        (calc_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_i) state_nx = (byte_num_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if ((ar_hs && (ar_left == BW'(cur_len))) || (halt && !ar_valid)) state_nx = ST_DRAIN;
            // Nothing outstanding means the final beat's write has just been issued.
            ST_DRAIN: if (outstanding == '0) state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_addr     <= '0;
            ar_len      <= '0;
            ar_valid    <= 1'b0;
            ar_left     <= '0;
            total       <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            off         <= '0;
            end_off     <= '0;
            error_o     <= 1'b0;
            sram_we_o   <= 1'b0;
            sram_be_o   <= '0;
            sram_addr_o <= '0;
            sram_data_o <= '0;
        end else begin
            sram_we_o <= r_hs && !halt;
            if (r_hs) begin
                sram_be_o   <= first_m & last_m;
                sram_data_o <= M_AXI_RDATA;
                r_cnt       <= r_cnt + BW'(1);
            end
            if (sram_we_o) sram_addr_o <= sram_addr_o + SRAM_ADDR_WIDTH'(1);
            if (r_err) error_o <= 1'b1;
            if (ar_hs) begin
                ar_valid <= 1'b0;
                ar_addr  <= ar_addr + (AXI_ADDR_WIDTH'(cur_len) << OFF_W);
                ar_left  <= ar_left - BW'(cur_len);
            end else if (ar_issue) begin
                ar_valid <= 1'b1;
                ar_len   <= 8'(calc_len - 9'd1);
            end
            if (ar_hs && !r_end)      outstanding <= outstanding + OW'(1);
            else if (!ar_hs && r_end) outstanding <= outstanding - OW'(1);
            if (start_ok) begin
                ar_addr     <= {base_addr_i[AXI_ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                ar_left     <= start_beats;
                total       <= start_beats;
                r_cnt       <= '0;
                sram_addr_o <= '0;
                error_o     <= 1'b0;
                off         <= base_addr_i[OFF_W-1:0];
                end_off     <= start_sum[OFF_W-1:0];
            end
        end
    end

endmodule
